// File: rtl/wb_counter_regs.sv
`default_nettype none
// ============================================================================
// Module   : wb_counter_regs
// Brief    : Wishbone B4 classic register slave that controls an up/down counter.
//            It also turns counter wrap events into sticky flags and a level IRQ.
// Revision : 1.0
// ============================================================================
module wb_counter_regs #(
    parameter int CNT_W = 4,
    parameter int WB_DW = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               wb_cyc_i,
    input  logic               wb_stb_i,
    input  logic               wb_we_i,
    input  logic [3:0]         wb_adr_i,
    input  logic [WB_DW-1:0]   wb_dat_i,
    input  logic [WB_DW/8-1:0] wb_sel_i,
    output logic [WB_DW-1:0]   wb_dat_o,
    output logic               wb_ack_o,
    output logic               cnt_en_o,
    output logic               cnt_up_down_o,
    input  logic [CNT_W-1:0]   cnt_count_i,
    output logic               irq_o
);

    localparam logic [1:0]       c_ADR_CTRL   = 2'd0;
    localparam logic [1:0]       c_ADR_COUNT  = 2'd1;
    localparam logic [1:0]       c_ADR_STATUS = 2'd2;
    localparam logic [CNT_W-1:0] c_CNT_ONES   = '1;
    localparam logic [CNT_W-1:0] c_CNT_ZERO   = '0;

    logic             r_ack;
    logic [WB_DW-1:0] r_dat;
    logic             r_en;
    logic             r_up;
    logic             r_ovf;
    logic             r_unf;
    logic             r_ovf_ie;
    logic             r_unf_ie;
    logic             r_irq;
    logic [CNT_W-1:0] r_prev_cnt;

    logic             w_req;
    logic             w_wr;
    logic             w_ctrl_wr;
    logic             w_status_wr;
    logic             w_ie_wr;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic             w_ovf_clr;
    logic             w_unf_clr;
    logic [WB_DW-1:0] w_rd_data;
    logic             w_unused;

    // A request is never re-accepted while its ack is still on the bus.
    assign w_req       = wb_cyc_i & wb_stb_i & ~r_ack;
    assign w_wr        = w_req & wb_we_i & wb_sel_i[0];
    assign w_ctrl_wr   = w_wr && (wb_adr_i[3:2] == c_ADR_CTRL);
    assign w_status_wr = w_wr && (wb_adr_i[3:2] == c_ADR_STATUS);
    assign w_ie_wr     = w_wr && (wb_adr_i[3:2] == 2'd3);

    assign w_ovf_evt = (r_prev_cnt == c_CNT_ONES) && (cnt_count_i == c_CNT_ZERO);
    assign w_unf_evt = (r_prev_cnt == c_CNT_ZERO) && (cnt_count_i == c_CNT_ONES);
    assign w_ovf_clr = w_status_wr & wb_dat_i[0];
    assign w_unf_clr = w_status_wr & wb_dat_i[1];

    assign w_unused = &{1'b0, wb_sel_i, wb_dat_i, wb_adr_i[1:0]};

    always_comb begin
        w_rd_data = '0;
        case (wb_adr_i[3:2])
            c_ADR_CTRL:   w_rd_data[1:0]       = {r_up, r_en};
            c_ADR_COUNT:  w_rd_data[CNT_W-1:0] = cnt_count_i;
            c_ADR_STATUS: w_rd_data[1:0]       = {r_unf, r_ovf};
            default:      w_rd_data[1:0]       = {r_unf_ie, r_ovf_ie};
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack      <= 1'b0;
            r_dat      <= '0;
            r_en       <= 1'b0;
            r_up       <= 1'b1;
            r_ovf      <= 1'b0;
            r_unf      <= 1'b0;
            r_ovf_ie   <= 1'b0;
            r_unf_ie   <= 1'b0;
            r_irq      <= 1'b0;
            r_prev_cnt <= '0;
        end else begin
            r_ack      <= w_req;
            r_dat      <= (w_req && !wb_we_i) ? w_rd_data : '0;
            r_prev_cnt <= cnt_count_i;
            if (w_ctrl_wr) begin
                r_en <= wb_dat_i[0];
                r_up <= wb_dat_i[1];
            end
            if (w_ie_wr) begin
                r_ovf_ie <= wb_dat_i[0];
                r_unf_ie <= wb_dat_i[1];
            end
            // A new wrap event outranks a clear landing in the same cycle.
            r_ovf <= w_ovf_evt | (r_ovf & ~w_ovf_clr);
            r_unf <= w_unf_evt | (r_unf & ~w_unf_clr);
            r_irq <= (r_ovf & r_ovf_ie) | (r_unf & r_unf_ie);
        end
    end

    assign wb_ack_o      = r_ack;
    assign wb_dat_o      = r_dat;
    assign cnt_en_o      = r_en;
    assign cnt_up_down_o = r_up;
    assign irq_o         = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_wb_counter_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_counter_regs
// Brief    : Directed bench for wb_counter_regs with a 4-bit counter model and
//            an ack-driven scoreboard for bus responses.
// Revision : 1.0
// ============================================================================
module tb_wb_counter_regs;

    localparam int CNT_W = 4;
    localparam int WB_DW = 32;

    logic               clk;
    logic               rst_n;
    logic               wb_cyc_i;
    logic               wb_stb_i;
    logic               wb_we_i;
    logic [3:0]         wb_adr_i;
    logic [WB_DW-1:0]   wb_dat_i;
    logic [WB_DW/8-1:0] wb_sel_i;
    logic [WB_DW-1:0]   wb_dat_o;
    logic               wb_ack_o;
    logic               cnt_en_o;
    logic               cnt_up_down_o;
    logic [CNT_W-1:0]   cnt_count;
    logic               irq_o;

    wb_counter_regs #(.CNT_W(CNT_W), .WB_DW(WB_DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wb_cyc_i      (wb_cyc_i),
        .wb_stb_i      (wb_stb_i),
        .wb_we_i       (wb_we_i),
        .wb_adr_i      (wb_adr_i),
        .wb_dat_i      (wb_dat_i),
        .wb_sel_i      (wb_sel_i),
        .wb_dat_o      (wb_dat_o),
        .wb_ack_o      (wb_ack_o),
        .cnt_en_o      (cnt_en_o),
        .cnt_up_down_o (cnt_up_down_o),
        .cnt_count_i   (cnt_count),
        .irq_o         (irq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the external up/down counter fed by the DUT's control outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        cnt_count <= '0;
        else if (cnt_en_o) cnt_count <= cnt_up_down_o ? cnt_count + 4'd1 : cnt_count - 4'd1;
    end

    int cyc_n = 0;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    typedef struct {
        logic [31:0] data;
        bit          chk;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_chk  = 0;
    int   n_fail = 0;

    always @(negedge clk) begin
        if (wb_ack_o) begin
            n_chk++;
            if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: ack=1 at cycle %0d, required no ack", cyc_n);
            end else begin
                mon_e = sbq.pop_front();
                if (cyc_n != mon_e.cyc) begin
                    n_fail++;
                    $display("FAIL %s_ack_cycle: got %0d, expected %0d", mon_e.name, cyc_n, mon_e.cyc);
                end
                if (mon_e.chk) begin
                    n_chk++;
                    if (wb_dat_o !== mon_e.data) begin
                        n_fail++;
                        $display("FAIL %s_data: got 0x%08h, expected 0x%08h", mon_e.name, wb_dat_o, mon_e.data);
                    end
                end
            end
        end else begin
            n_chk++;
            if (wb_dat_o !== '0) begin
                n_fail++;
                $display("FAIL idle_dat: got 0x%08h while ack=0, expected 0", wb_dat_o);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic xfer(input bit we, input logic [3:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [31:0] exp_d, input bit chk_d,
                        input string name);
        exp_t e;
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = we;
        wb_adr_i = adr;
        wb_dat_i = dat;
        wb_sel_i = sel;
        e.data = exp_d;
        e.chk  = chk_d;
        e.cyc  = cyc_n + 1;
        e.name = name;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [3:0] adr, input logic [31:0] dat, input string name);
        xfer(1'b1, adr, dat, 4'h1, 32'h0, 1'b0, name);
    endtask

    task automatic rd(input logic [3:0] adr, input logic [31:0] exp, input string name);
        xfer(1'b0, adr, 32'h0, 4'hF, exp, 1'b1, name);
    endtask

    initial begin
        rst_n    = 1'b0;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        wb_adr_i = '0;
        wb_dat_i = '0;
        wb_sel_i = '0;
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;

        chk("rst_irq", 32'(irq_o), 32'h0);
        chk("rst_en", 32'(cnt_en_o), 32'h0);
        chk("rst_up", 32'(cnt_up_down_o), 32'h1);
        rd(4'h0, 32'h2, "rst_ctrl");
        rd(4'h8, 32'h0, "rst_status");
        rd(4'hC, 32'h0, "rst_irq_en");
        rd(4'h4, 32'h0, "rst_count");

        // Count up through 16 edges, stopping right after the F->0 wrap.
        wr(4'h0, 32'h3, "wr_ctrl_up");
        chk("en_after_wr", 32'(cnt_en_o), 32'h1);
        repeat (14) @(posedge clk);
        wr(4'h0, 32'h2, "wr_ctrl_stop");
        rd(4'h4, 32'h0, "count_wrapped");
        rd(4'h8, 32'h1, "status_ovf");

        wr(4'hC, 32'h1, "wr_ovf_ie");
        chk("irq_ack_edge", 32'(irq_o), 32'h0);
        @(posedge clk);
        #1 chk("irq_rise", 32'(irq_o), 32'h1);
        wr(4'h8, 32'h0, "wr_status_0");
        rd(4'h8, 32'h1, "status_w0_keep");
        chk("irq_w0_keep", 32'(irq_o), 32'h1);
        wr(4'h8, 32'h1, "w1c_ovf");
        chk("irq_clr_edge", 32'(irq_o), 32'h1);
        @(posedge clk);
        #1 chk("irq_fall", 32'(irq_o), 32'h0);
        rd(4'h8, 32'h0, "status_cleared");

        // Count down from 0: underflow flag, then the interrupt one edge later.
        wr(4'hC, 32'h3, "wr_both_ie");
        wr(4'h0, 32'h1, "wr_ctrl_down");
        chk("en_down", 32'(cnt_en_o), 32'h1);
        chk("updown_down", 32'(cnt_up_down_o), 32'h0);
        @(posedge clk);
        #1 chk("irq_unf_n1", 32'(irq_o), 32'h0);
        @(posedge clk);
        #1 chk("irq_unf_n2", 32'(irq_o), 32'h0);
        @(posedge clk);
        #1 chk("irq_unf_n3", 32'(irq_o), 32'h1);
        wr(4'h0, 32'h0, "wr_ctrl_off");
        rd(4'h4, 32'hB, "count_down");
        rd(4'h8, 32'h2, "status_unf");
        rd(4'h0, 32'h0, "ctrl_off");
        wr(4'h8, 32'h2, "w1c_unf");
        rd(4'h8, 32'h0, "status_unf_clr");
        chk("irq_unf_cleared", 32'(irq_o), 32'h0);

        // W1C of OVF lands on the same edge the flag is set by a wrap.
        wr(4'h0, 32'h3, "wr_ctrl_up2");
        repeat (4) @(posedge clk);
        wr(4'h8, 32'h1, "w1c_at_wrap");
        wr(4'h0, 32'h2, "wr_ctrl_stop2");
        rd(4'h8, 32'h1, "set_beats_clr");
        rd(4'h7, 32'h3, "count_alias_adr");

        xfer(1'b1, 4'h0, 32'h1, 4'h0, 32'h0, 1'b0, "wr_ctrl_sel0");
        rd(4'h0, 32'h2, "ctrl_sel0_kept");
        chk("en_sel0", 32'(cnt_en_o), 32'h0);

        @(posedge clk);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 4'h0;
        wb_dat_i = 32'h1;
        wb_sel_i = 4'h1;
        #3;
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        repeat (2) @(posedge clk);
        rd(4'h0, 32'h2, "ctrl_stb_drop");

        // Reset while the ack of a write is on the bus.
        @(posedge clk);
        #1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        wb_we_i  = 1'b1;
        wb_adr_i = 4'h0;
        wb_dat_i = 32'h1;
        wb_sel_i = 4'h1;
        @(posedge clk);
        #1 chk("ack_before_rst", 32'(wb_ack_o), 32'h1);
        rst_n = 1'b0;
        #1 chk("ack_rst_drop", 32'(wb_ack_o), 32'h0);
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        chk("rst2_en", 32'(cnt_en_o), 32'h0);
        chk("rst2_up", 32'(cnt_up_down_o), 32'h1);
        chk("rst2_irq", 32'(irq_o), 32'h0);
        #20;
        @(posedge clk);
        #1 rst_n = 1'b1;
        rd(4'h0, 32'h2, "rst2_ctrl");
        rd(4'h8, 32'h0, "rst2_status");
        rd(4'hC, 32'h0, "rst2_irq_en");
        rd(4'h4, 32'h0, "rst2_count");

        repeat (3) @(posedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/wb_counter_regs.md
# wb_counter_regs

Wishbone B4 classic slave that exposes the 4-bit up/down counter to the SoC bus. It drives the counter's `en` and `up_down` inputs from a control register, reads back `count`, detects wrap-around events into sticky flags, and raises a level interrupt. It sits between the Wishbone interconnect and the counter, sharing the counter's clock and reset.

## Interface
- `CNT_W`, 4: counter width; must match the counter's `count` width.
- `WB_DW`, 32: Wishbone data width; only bits [CNT_W-1:0] carry data.
- `clk`  in  1  system clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset, same net as the counter's `rst_n`.
- `wb_cyc_i`  in  1  bus cycle valid.
- `wb_stb_i`  in  1  strobe / slave select.
- `wb_we_i`  in  1  1 = write, 0 = read.
- `wb_adr_i`  in  4  byte address; only [3:2] are decoded.
- `wb_dat_i`  in  WB_DW  write data.
- `wb_sel_i`  in  WB_DW/8  byte enables; only bit 0 is used.
- `wb_dat_o`  out  WB_DW  read data, valid while `wb_ack_o`=1.
- `wb_ack_o`  out  1  transfer acknowledge.
- `cnt_en_o`  out  1  to counter `en`.
- `cnt_up_down_o`  out  1  to counter `up_down` (1 = up).
- `cnt_count_i`  in  CNT_W  from counter `count`.
- `irq_o`  out  1  level interrupt, active high.

## Operation
- Register map (`wb_adr_i[3:2]`):
  - 0x0 CTRL, RW: bit0 EN, bit1 UP. Reset EN=0, UP=1. Bits drive `cnt_en_o` and `cnt_up_down_o` directly.
  - 0x4 COUNT, RO: bits[CNT_W-1:0] = `cnt_count_i`. Writes ignored.
  - 0x8 STATUS, W1C: bit0 OVF (all-ones→0), bit1 UNF (0→all-ones). Reset 0. Writing 1 clears, writing 0 has no effect.
  - 0xC IRQ_EN, RW: bit0 OVF_IE, bit1 UNF_IE. Reset 0.
- Unused read bits return 0. Writes take effect only when `wb_sel_i[0]`=1.
- Wrap detection: `prev_cnt` register (reset 0) samples `cnt_count_i` every cycle. OVF sets when `prev_cnt`=all-ones and `cnt_count_i`=0. UNF sets when `prev_cnt`=0 and `cnt_count_i`=all-ones. Detection is independent of UP; both are sticky.
- Simultaneous set and W1C clear of the same flag in one cycle: set wins, flag stays 1.
- `irq_o` is registered: `irq_o` <= |(STATUS & IRQ_EN).
- All outputs reset to 0 except `cnt_up_down_o`=1. Reset assertion mid-transfer drops `wb_ack_o` immediately; the transfer is lost.

## Timing
- Request = `wb_cyc_i & wb_stb_i & !wb_ack_o`. `wb_ack_o` asserts on the edge following the request, stays high for exactly one cycle, then deasserts. Back-to-back requests therefore complete every 2 cycles. `wb_ack_o` never asserts without `wb_cyc_i & wb_stb_i`.
- Writes: the register updates on the same edge that asserts `wb_ack_o`. CTRL changes reach the counter starting from the first edge after ack.
- Reads: `wb_dat_o` is captured on the ack edge from pre-update register values and `cnt_count_i`. It is driven 0 when `wb_ack_o`=0.
- Flag latency: the counter changes `count` at edge N, the flag sets at edge N+1, and `irq_o` rises at edge N+2. After a W1C clear at edge M, `irq_o` falls at edge M+1 (absent a new event).
- Unmapped addresses do not exist: all 4 word slots decode. Bits `wb_adr_i[1:0]` are ignored.
- If `wb_stb_i` drops before ack, no ack is issued and no write occurs.

## Test plan
- Reset: hold `rst_n`=0 for 20 ns, release on clk edge +1 ns -> CTRL reads 0x2, STATUS 0x0, IRQ_EN 0x0, `irq_o`=0, `cnt_en_o`=0, `cnt_up_down_o`=1.
- Write CTRL=0x3, `wb_sel_i`=0x1 -> ack 1 cycle after strobe; `cnt_en_o`=1. After 16 counter edges COUNT reads back the wrapped value; STATUS bit0=1, bit1=0.
- Write IRQ_EN=0x1 with OVF pending -> `irq_o`=1 one cycle after the ack edge. Write STATUS=0x1 -> OVF=0 and `irq_o`=0 one cycle later. Write STATUS=0x0 -> no change.
- Write CTRL=0x1 (down) at count 0 -> UNF sets on the edge after count becomes 0xF; with UNF_IE=1, `irq_o` rises the following edge.
- W1C of OVF issued in the same cycle the counter wraps F→0 -> OVF remains 1.
- Write with `wb_sel_i`=0x0, and a strobe withdrawn before ack -> no register change. Assert `rst_n`=0 while ack is high -> ack drops immediately and all registers return to reset values.
